// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite constants and byte-lane helpers used by the exclusive-access SRAM responder.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StErr1,
    StErr2
  } resp_state_e;

  // Byte lanes touched by a transfer; lo is expected to be already aligned to the size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << lo;
      HSIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ahbl_excl_sram_responder_if.sv
// AHB-Lite slave port bundle with the hexcl/hmaster/hexokay exclusive-access extension.
interface ahbl_excl_sram_responder_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;
  logic              hexcl;
  logic [7:0]        hmaster;
  logic              hexokay;

  modport master (
    output hready, haddr, hwrite, htrans, hsize, hwdata, hexcl, hmaster,
    input  hready_resp, hresp, hrdata, hexokay
  );

  modport slave (
    input  hready, haddr, hwrite, htrans, hsize, hwdata, hexcl, hmaster,
    output hready_resp, hresp, hrdata, hexokay
  );
endinterface

// File: rtl/ahbl_excl_monitor.sv
// Per-master reservation table: one {valid, word index} entry per master ID below N_MASTERS.
module ahbl_excl_monitor #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_i,
  input  logic          clr_match_i,
  input  logic          clr_id_i,
  input  logic [7:0]    id_i,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o
);

  logic [N_MASTERS-1:0] valid_q, valid_d;
  logic [AW-1:0]        addr_q [N_MASTERS];
  logic [AW-1:0]        addr_d [N_MASTERS];

  // IDs outside the table match no entry, so they can never hold a reservation.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    hit_o   = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (id_i == 8'(i) && valid_q[i] && addr_q[i] == addr_i) hit_o = 1'b1;
      if (clr_match_i && addr_q[i] == addr_i) valid_d[i] = 1'b0;
      if (clr_id_i && id_i == 8'(i)) valid_d[i] = 1'b0;
      if (set_i && id_i == 8'(i)) begin
        valid_d[i] = 1'b1;
        addr_d[i]  = addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    addr_q <= addr_d;
  end

endmodule

// File: rtl/ahbl_excl_sram_responder.sv
// AHB-Lite SRAM slave with exclusive-access responder; define AHBL_EXCL_RESP_ERR_EN to return
// two-cycle ERROR responses for misaligned or out-of-range transfers.
module ahbl_excl_sram_responder
  import ahbl_pkg::*;
#(
  parameter int unsigned W_ADDR    = 32,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned N_MASTERS = 4
) (
  input logic                       clk,
  input logic                       rst,
  ahbl_excl_sram_responder_if.slave ahbls
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              accept;
  logic              a_bad;
  logic [1:0]        a_lo;
  logic [AW-1:0]     a_idx;
  logic [W_DATA-1:0] rd_word;
  logic              hready_resp;
  logic              hresp;

  logic              dp_valid_q, dp_write_q, dp_excl_q, dp_err_q;
  logic [2:0]        dp_size_q;
  logic [1:0]        dp_lo_q;
  logic [AW-1:0]     dp_idx_q;
  logic [7:0]        dp_master_q;
  logic [W_DATA-1:0] rdata_q;

  logic [3:0]        wmask;
  logic              live, dp_end, excl_size_ok, master_ok, mon_hit;
  logic              commit, mon_set, mon_clr_id;
  logic              unused_addr;

  logic [W_DATA-1:0] mem [DEPTH];

  assign accept      = ahbls.hready && ahbls.htrans[1];
  assign a_idx       = ahbls.haddr[2 +: AW];
  assign unused_addr = ^{ahbls.htrans[0], ahbls.haddr[W_ADDR-1:2+AW]};

  always_comb begin
    a_lo = ahbls.haddr[1:0];
    if (ahbls.hsize == HSIZE_HALF) begin
      a_lo[0] = 1'b0;
    end else if (ahbls.hsize != HSIZE_BYTE) begin
      a_lo = 2'b00;
    end
  end

`ifdef AHBL_EXCL_RESP_ERR_EN
  resp_state_e state_q, state_d;

  assign a_bad = (ahbls.hsize == HSIZE_HALF && ahbls.haddr[0]) ||
                 (ahbls.hsize == HSIZE_WORD && ahbls.haddr[1:0] != 2'b00) ||
                 ({2'b00, ahbls.haddr[W_ADDR-1:2]} >= W_ADDR'(DEPTH));

  // A new bad transfer can be accepted in StErr2, restarting the error sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept && a_bad) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = (accept && a_bad) ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign hready_resp = (state_q != StErr1);
  assign hresp       = (state_q == StIdle) ? HRESP_OKAY : HRESP_ERROR;
`else
  assign a_bad       = 1'b0;
  assign hready_resp = 1'b1;
  assign hresp       = HRESP_OKAY;
`endif

  assign wmask        = lane_mask(dp_size_q, dp_lo_q);
  assign live         = dp_valid_q && !dp_err_q;
  assign dp_end       = dp_valid_q && hready_resp;
  assign excl_size_ok = (dp_size_q == HSIZE_WORD);
  assign master_ok    = (dp_master_q < 8'(N_MASTERS));

  assign commit     = dp_end && !rst && live && dp_write_q &&
                      (!dp_excl_q || (excl_size_ok && mon_hit));
  assign mon_set    = dp_end && live && dp_excl_q && !dp_write_q && excl_size_ok;
  assign mon_clr_id = dp_end && live && dp_excl_q && dp_write_q;

  ahbl_excl_monitor #(
    .N_MASTERS (N_MASTERS),
    .AW        (AW)
  ) u_monitor (
    .clk         (clk),
    .rst         (rst),
    .set_i       (mon_set),
    .clr_match_i (commit),
    .clr_id_i    (mon_clr_id),
    .id_i        (dp_master_q),
    .addr_i      (dp_idx_q),
    .hit_o       (mon_hit)
  );

  // Forward the bytes of a write committing this edge into a read of the same word.
  always_comb begin
    rd_word = mem[a_idx];
    if (commit && dp_idx_q == a_idx) begin
      rd_word = merge_lanes(rd_word, ahbls.hwdata, wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[dp_idx_q] <= merge_lanes(mem[dp_idx_q], ahbls.hwdata, wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_excl_q   <= 1'b0;
      dp_err_q    <= 1'b0;
      dp_size_q   <= HSIZE_BYTE;
      dp_lo_q     <= 2'b00;
      dp_idx_q    <= '0;
      dp_master_q <= '0;
      rdata_q     <= '0;
    end else if (ahbls.hready) begin
      dp_valid_q  <= accept;
      dp_write_q  <= ahbls.hwrite;
      dp_excl_q   <= ahbls.hexcl;
      dp_err_q    <= accept && a_bad;
      dp_size_q   <= ahbls.hsize;
      dp_lo_q     <= a_lo;
      dp_idx_q    <= a_idx;
      dp_master_q <= ahbls.hmaster;
      rdata_q     <= (accept && !ahbls.hwrite && !a_bad) ? rd_word : '0;
    end
  end

  assign ahbls.hready_resp = hready_resp;
  assign ahbls.hresp       = hresp;
  assign ahbls.hrdata      = (live && !dp_write_q) ? rdata_q : '0;
  assign ahbls.hexokay     = hready_resp && live && dp_excl_q && excl_size_ok &&
                             (dp_write_q ? mon_hit : master_ok);

endmodule

// File: tb/tb_ahbl_excl_sram_responder.sv
// Bench for ahbl_excl_sram_responder: directed vector table, pipelined corner cases and a
// randomized run against a reservation/memory reference model.
`timescale 1ns/1ps
module tb_ahbl_excl_sram_responder;
  import ahbl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahbl_excl_sram_responder_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  assign bus.hready = bus.hready_resp;

  ahbl_excl_sram_responder #(
    .W_ADDR    (32),
    .W_DATA    (32),
    .DEPTH     (1024),
    .N_MASTERS (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ahbls (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        excl;
    logic [7:0]  mst;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_op(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic excl, input logic [7:0] mst, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic okay, output logic err);
    int n;
    bus.htrans = HTRANS_NSEQ; bus.haddr = addr; bus.hwrite = wr; bus.hsize = size;
    bus.hexcl = excl; bus.hmaster = mst;
    @(posedge clk); #1;
    bus.htrans = HTRANS_IDLE; bus.hexcl = 1'b0; bus.hwdata = wdata;
    n = 0;
    while (!bus.hready_resp && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.hready_resp) check("data phase timeout", 32'(bus.hready_resp), 32'd1);
    rdata = bus.hrdata; okay = bus.hexokay; err = bus.hresp;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string name, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic excl, input logic [7:0] mst,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_ok);
    logic [31:0] rd;
    logic ok, err;
    bus_op(wr, addr, size, excl, mst, wdata, rd, ok, err);
    check({name, " hrdata"}, rd, exp_rd);
    check({name, " hexokay"}, 32'(ok), 32'(exp_ok));
    check({name, " hresp"}, 32'(err), 32'(HRESP_OKAY));
  endtask

  task automatic add(input string name, input logic wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic excl, input logic [7:0] mst,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_ok);
    vecs.push_back('{name, wr, addr, size, excl, mst, wdata, exp_rd, exp_ok});
  endtask

  // Reference model for the random run: words 0x100 + 4*k, k in 0..7.
  logic [31:0] m_mem [8];
  bit          r_valid [4];
  int          r_word  [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic ok, err;

    bus.htrans = HTRANS_IDLE; bus.haddr = '0; bus.hwrite = 1'b0; bus.hsize = HSIZE_WORD;
    bus.hexcl = 1'b0; bus.hmaster = '0; bus.hwdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset hready_resp", 32'(bus.hready_resp), 32'd1);
    check("reset hresp", 32'(bus.hresp), 32'd0);
    check("reset hexokay", 32'(bus.hexokay), 32'd0);
    check("reset hrdata", bus.hrdata, 32'd0);

    // Reset in the middle of a write data phase abandons it and drops reservations.
    do_op("init 0x10", 1, 32'h10, HSIZE_WORD, 0, 0, 32'h01020304, 32'h0, 0);
    do_op("excl rd 0x10", 0, 32'h10, HSIZE_WORD, 1, 0, 32'h0, 32'h01020304, 1);
    bus.htrans = HTRANS_NSEQ; bus.haddr = 32'h10; bus.hwrite = 1'b1; bus.hsize = HSIZE_WORD;
    @(posedge clk); #1;
    bus.htrans = HTRANS_IDLE; bus.hwdata = 32'hDEADBEEF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid reset hready_resp", 32'(bus.hready_resp), 32'd1);
    check("mid reset hexokay", 32'(bus.hexokay), 32'd0);
    do_op("excl wr after reset", 1, 32'h10, HSIZE_WORD, 1, 0, 32'h99, 32'h0, 0);
    do_op("rd 0x10 after reset", 0, 32'h10, HSIZE_WORD, 0, 0, 32'h0, 32'h01020304, 0);

    // Back-to-back byte write then read of the same word.
    do_op("init 0x20", 1, 32'h20, HSIZE_WORD, 0, 0, 32'h0, 32'h0, 0);
    bus.htrans = HTRANS_NSEQ; bus.haddr = 32'h21; bus.hwrite = 1'b1; bus.hsize = HSIZE_BYTE;
    @(posedge clk); #1;
    bus.hwdata = 32'h0000AB00;
    bus.haddr = 32'h20; bus.hwrite = 1'b0; bus.hsize = HSIZE_WORD;
    @(posedge clk); #1;
    bus.htrans = HTRANS_IDLE;
    check("bypass hready_resp", 32'(bus.hready_resp), 32'd1);
    check("bypass hrdata", bus.hrdata, 32'h0000AB00);
    @(posedge clk); #1;

    // Exclusive read immediately followed by exclusive write sees the freshly set reservation.
    bus.htrans = HTRANS_NSEQ; bus.haddr = 32'h20; bus.hwrite = 1'b0; bus.hsize = HSIZE_WORD;
    bus.hexcl = 1'b1; bus.hmaster = 8'd1;
    @(posedge clk); #1;
    check("b2b excl rd hexokay", 32'(bus.hexokay), 32'd1);
    check("b2b excl rd hrdata", bus.hrdata, 32'h0000AB00);
    bus.hwrite = 1'b1;
    @(posedge clk); #1;
    bus.htrans = HTRANS_IDLE; bus.hexcl = 1'b0; bus.hwdata = 32'h77;
    check("b2b excl wr hexokay", 32'(bus.hexokay), 32'd1);
    @(posedge clk); #1;
    do_op("rd 0x20 after b2b", 0, 32'h20, HSIZE_WORD, 0, 0, 32'h0, 32'h77, 0);

    add("init 0x40",         1, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h0,        0);
    add("M0 excl rd",        0, 32'h40, HSIZE_WORD, 1, 0, 32'h0,        32'h0,        1);
    add("M0 excl wr",        1, 32'h40, HSIZE_WORD, 1, 0, 32'h1234,     32'h0,        1);
    add("rd after excl",     0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h1234,     0);
    add("M0 excl rd 2",      0, 32'h40, HSIZE_WORD, 1, 0, 32'h0,        32'h1234,     1);
    add("M1 plain wr",       1, 32'h40, HSIZE_WORD, 0, 1, 32'h5,        32'h0,        0);
    add("M0 excl wr lost",   1, 32'h40, HSIZE_WORD, 1, 0, 32'h9,        32'h0,        0);
    add("rd shows 5",        0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h5,        0);
    add("init 0x80",         1, 32'h80, HSIZE_WORD, 0, 0, 32'h11111111, 32'h0,        0);
    add("M7 excl rd",        0, 32'h80, HSIZE_WORD, 1, 7, 32'h0,        32'h11111111, 0);
    add("M7 excl wr",        1, 32'h80, HSIZE_WORD, 1, 7, 32'h22,       32'h0,        0);
    add("M7 wr suppressed",  0, 32'h80, HSIZE_WORD, 0, 0, 32'h0,        32'h11111111, 0);
    add("M2 half excl rd",   0, 32'h40, HSIZE_HALF, 1, 2, 32'h0,        32'h5,        0);
    add("M2 excl wr no res", 1, 32'h40, HSIZE_WORD, 1, 2, 32'h7,        32'h0,        0);
    add("rd still 5",        0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h5,        0);
    add("M1 excl rd",        0, 32'h40, HSIZE_WORD, 1, 1, 32'h0,        32'h5,        1);
    add("M3 excl rd",        0, 32'h40, HSIZE_WORD, 1, 3, 32'h0,        32'h5,        1);
    add("M1 excl wr wins",   1, 32'h40, HSIZE_WORD, 1, 1, 32'hA,        32'h0,        1);
    add("M3 excl wr loses",  1, 32'h40, HSIZE_WORD, 1, 3, 32'hB,        32'h0,        0);
    add("rd shows A",        0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'hA,        0);
    add("byte wr 0x43",      1, 32'h43, HSIZE_BYTE, 0, 0, 32'hCC000000, 32'h0,        0);
    add("half wr 0x42",      1, 32'h42, HSIZE_HALF, 0, 0, 32'h55660000, 32'h0,        0);
    add("rd merged",         0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h5566000A, 0);
    add("M0 excl rd 3",      0, 32'h40, HSIZE_WORD, 1, 0, 32'h0,        32'h5566000A, 1);
    add("M0 excl wr other",  1, 32'h80, HSIZE_WORD, 1, 0, 32'h33,       32'h0,        0);
    add("M0 excl wr cleared",1, 32'h40, HSIZE_WORD, 1, 0, 32'h44,       32'h0,        0);
    add("rd 0x40 intact",    0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h5566000A, 0);
    add("rd 0x80 intact",    0, 32'h80, HSIZE_WORD, 0, 0, 32'h0,        32'h11111111, 0);
    add("M0 excl rd 4",      0, 32'h40, HSIZE_WORD, 1, 0, 32'h0,        32'h5566000A, 1);
    add("M0 excl half wr",   1, 32'h40, HSIZE_HALF, 1, 0, 32'h7777,     32'h0,        0);
    add("rd after half excl",0, 32'h40, HSIZE_WORD, 0, 0, 32'h0,        32'h5566000A, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].excl, vecs[i].mst,
            vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_ok);
    end

`ifdef AHBL_EXCL_RESP_ERR_EN
    // Misaligned word read: ERROR over two cycles, next NSEQ taken in the second.
    bus.htrans = HTRANS_NSEQ; bus.haddr = 32'h42; bus.hwrite = 1'b0; bus.hsize = HSIZE_WORD;
    @(posedge clk); #1;
    check("err cycle1 hready_resp", 32'(bus.hready_resp), 32'd0);
    check("err cycle1 hresp", 32'(bus.hresp), 32'd1);
    check("err cycle1 hexokay", 32'(bus.hexokay), 32'd0);
    bus.haddr = 32'h40;
    @(posedge clk); #1;
    check("err cycle2 hready_resp", 32'(bus.hready_resp), 32'd1);
    check("err cycle2 hresp", 32'(bus.hresp), 32'd1);
    @(posedge clk); #1;
    bus.htrans = HTRANS_IDLE;
    check("after err hresp", 32'(bus.hresp), 32'd0);
    check("after err hrdata", bus.hrdata, 32'h5566000A);
    @(posedge clk); #1;
`endif

    // Randomized run against the reference model.
    for (int k = 0; k < 8; k++) begin
      m_mem[k] = $urandom;
      do_op("rand init", 1, 32'h100 + 32'(4 * k), HSIZE_WORD, 0, 0, m_mem[k], 32'h0, 0);
    end
    for (int j = 0; j < 4; j++) r_valid[j] = 1'b0;

    for (int n = 0; n < 300; n++) begin
      int          k, sz, lo, mst;
      bit          wr, excl, do_wr;
      logic [31:0] wd, exp_rd;
      bit          exp_ok;
      k    = $urandom_range(0, 3);
      sz   = $urandom_range(0, 2);
      lo   = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      wr   = $urandom_range(0, 1);
      excl = $urandom_range(0, 1);
      mst  = $urandom_range(0, 4);
      wd   = $urandom;
      exp_ok = 1'b0;
      exp_rd = 32'h0;
      if (!wr) begin
        exp_rd = m_mem[k];
        if (excl && sz == 2 && mst < 4) begin
          exp_ok = 1'b1;
          r_valid[mst] = 1'b1;
          r_word[mst]  = k;
        end
      end else begin
        do_wr = 1'b1;
        if (excl) begin
          do_wr  = (sz == 2) && (mst < 4) && r_valid[mst] && (r_word[mst] == k);
          exp_ok = do_wr;
          if (mst < 4) r_valid[mst] = 1'b0;
        end
        if (do_wr) begin
          for (int b = lo; b < lo + (1 << sz); b++) m_mem[k][8*b +: 8] = wd[8*b +: 8];
          for (int j = 0; j < 4; j++) if (r_word[j] == k) r_valid[j] = 1'b0;
        end
      end
      do_op($sformatf("rand op %0d", n), wr, 32'h100 + 32'(4 * k + lo), 3'(sz), excl,
            8'(mst), wd, exp_rd, exp_ok);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
